// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: the responder end of the dbus handshake, backed by a
// word-wide SRAM model. It takes a request and holds it for LATENCY cycles,
// then answers with one addr_ok/data_ok pulse carrying the word as it was
// before any write. A backdoor write port lets a bench preload the SRAM.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   dreq     in   dbus_req_t  {valid, addr, size, strobe, data}
//   dresp    out  dbus_resp_t {addr_ok, data_ok, data}
//   bd_we    in   backdoor write enable
//   bd_addr  in   backdoor word index
//   bd_data  in   backdoor write word
//   busy     out  high while the FSM is not idle

package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  dbus_req_t             dreq,
  output dbus_resp_t            dresp,
  input  logic                  bd_we,
  input  logic [DEPTH_LOG2-1:0] bd_addr,
  input  logic [63:0]           bd_data,
  output logic                  busy
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dbus_sram_responder: LATENCY must be within 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [7:0]            strobe_q, strobe_d;
  logic [63:0]           data_q, data_d;
  logic [63:0]           rdata_q;
  logic                  resp;

  logic [63:0] mem [0:(1 << DEPTH_LOG2) - 1];

  // Address bits outside the word index and the size field do not matter.
  logic unused_req_bits;
  assign unused_req_bits = ^{dreq.addr[63:DEPTH_LOG2+3], dreq.addr[2:0], dreq.size};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    strobe_d = strobe_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (dreq.valid) begin
          idx_d    = dreq.addr[DEPTH_LOG2+2:3];
          strobe_d = dreq.strobe;
          data_d   = dreq.data;
          cnt_d    = CNT_INIT;
          state_d  = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!dreq.valid) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      strobe_q <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
      if (state_q == RESP) rdata_q <= mem[idx_q];
    end
  end

  // Bus write is issued after the backdoor write so it overrides the strobed
  // bytes when both hit the same word on the same edge.
  always_ff @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (state_q == RESP) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (strobe_q[i]) mem[idx_q][8*i +: 8] <= data_q[8*i +: 8];
      end
    end
  end

  // The RESP cycle shows the pre-write word straight from the array; rdata_q
  // keeps that value visible afterwards.
  assign resp          = (state_q == RESP);
  assign dresp.addr_ok = resp;
  assign dresp.data_ok = resp;
  assign dresp.data    = resp ? mem[idx_q] : rdata_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_dbus_sram_responder.sv
module tb_dbus_sram_responder;
  import dbus_pkg::*;

  logic        clk;
  logic        rst;
  dbus_req_t   req     [3];
  dbus_resp_t  rsp     [3];
  logic        bd_we   [3];
  logic [9:0]  bd_addr [3];
  logic [63:0] bd_data [3];
  logic        busy    [3];

  int unsigned total;
  int unsigned passed;

  // Instance k runs with LATENCY = k+1.
  for (genvar k = 0; k < 3; k++) begin : g_dut
    dbus_sram_responder #(.DEPTH_LOG2(10), .LATENCY(k + 1)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .dreq   (req[k]),
      .dresp  (rsp[k]),
      .bd_we  (bd_we[k]),
      .bd_addr(bd_addr[k]),
      .bd_data(bd_data[k]),
      .busy   (busy[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic bd_write(input int k, input logic [9:0] idx, input logic [63:0] d);
    bd_we[k]   = 1'b1;
    bd_addr[k] = idx;
    bd_data[k] = d;
    @(posedge clk); #1;
    bd_we[k]   = 1'b0;
  endtask

  task automatic txn(input int k, input logic [63:0] addr, input logic [7:0] strb,
                     input logic [63:0] wd, input logic [63:0] exp, input string tag);
    int unsigned cyc;
    bit seen;
    cyc = 0;
    seen = 0;
    req[k].valid  = 1'b1;
    req[k].addr   = addr;
    req[k].strobe = strb;
    req[k].data   = wd;
    req[k].size   = 3'd3;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (rsp[k].data_ok) seen = 1;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(k + 1));
    chk({tag, "_addr_ok"}, 64'(rsp[k].addr_ok), 64'd1);
    chk({tag, "_data"}, rsp[k].data, exp);
    req[k].valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_ok_low"}, 64'(rsp[k].data_ok), 64'd0);
    chk({tag, "_idle"}, 64'(busy[k]), 64'd0);
    chk({tag, "_hold"}, rsp[k].data, exp);
  endtask

  typedef struct {
    int          inst;
    logic [63:0] addr;
    logic [7:0]  strb;
    logic [63:0] wd;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    bit seen;
    total  = 0;
    passed = 0;

    vecs[0] = '{1, 64'h28,   8'h00, 64'h0,                   64'h1122334455667788};
    vecs[1] = '{1, 64'h28,   8'h0F, 64'hAAAAAAAA_DEADBEEF,   64'h1122334455667788};
    vecs[2] = '{1, 64'h28,   8'h00, 64'h0,                   64'h11223344_DEADBEEF};
    vecs[3] = '{1, 64'h2008, 8'hFF, 64'hCAFEBABE_0BADF00D,   64'h0101010101010101};
    vecs[4] = '{1, 64'h08,   8'h00, 64'h0,                   64'hCAFEBABE_0BADF00D};
    vecs[5] = '{1, 64'h2D,   8'h00, 64'h0,                   64'h11223344_DEADBEEF};
    vecs[6] = '{2, 64'h38,   8'h00, 64'h0,                   64'h77770000_12345678};
    vecs[7] = '{2, 64'h38,   8'h80, 64'hEE112233_44556677,   64'h77770000_12345678};
    vecs[8] = '{2, 64'h38,   8'h00, 64'h0,                   64'hEE770000_12345678};
    vecs[9] = '{0, 64'h08,   8'h00, 64'h0,                   64'hA1A1A1A1_A1A1A1A1};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req[k]     = '0;
      bd_we[k]   = 1'b0;
      bd_addr[k] = '0;
      bd_data[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_data_ok", 64'(rsp[k].data_ok), 64'd0);
      chk("reset_addr_ok", 64'(rsp[k].addr_ok), 64'd0);
      chk("reset_data", rsp[k].data, 64'd0);
      chk("reset_busy", 64'(busy[k]), 64'd0);
    end
    rst = 1'b0;

    bd_write(1, 10'd5, 64'h1122334455667788);
    bd_write(1, 10'd1, 64'h0101010101010101);
    bd_write(0, 10'd1, 64'hA1A1A1A1_A1A1A1A1);
    bd_write(0, 10'd2, 64'hA2A2A2A2_A2A2A2A2);
    bd_write(2, 10'd7, 64'h77770000_12345678);

    for (int i = 0; i < 10; i++) begin
      txn(vecs[i].inst, vecs[i].addr, vecs[i].strb, vecs[i].wd, vecs[i].exp,
          $sformatf("vec%0d", i));
    end

    // Request abandoned during WAIT (LATENCY=3).
    bd_write(2, 10'd3, 64'h33333333_33333333);
    req[2].valid  = 1'b1;
    req[2].addr   = 64'h18;
    req[2].strobe = 8'hFF;
    req[2].data   = 64'hFFFFFFFF_FFFFFFFF;
    @(posedge clk); #1;
    chk("abort_busy_wait", 64'(busy[2]), 64'd1);
    req[2].valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy_idle", 64'(busy[2]), 64'd0);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (rsp[2].data_ok) seen = 1;
      @(posedge clk); #1;
    end
    chk("abort_no_resp", 64'(seen), 64'd0);
    txn(2, 64'h18, 8'h00, 64'h0, 64'h33333333_33333333, "abort_read");

    // Back-to-back reads with valid held (LATENCY=1).
    req[0].valid  = 1'b1;
    req[0].addr   = 64'h08;
    req[0].strobe = 8'h00;
    @(posedge clk); #1;
    chk("b2b_first_ok", 64'(rsp[0].data_ok), 64'd1);
    chk("b2b_first_data", rsp[0].data, 64'hA1A1A1A1_A1A1A1A1);
    req[0].addr = 64'h10;
    @(posedge clk); #1;
    chk("b2b_gap", 64'(rsp[0].data_ok), 64'd0);
    @(posedge clk); #1;
    chk("b2b_second_ok", 64'(rsp[0].data_ok), 64'd1);
    chk("b2b_second_data", rsp[0].data, 64'hA2A2A2A2_A2A2A2A2);
    req[0].valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end_ok", 64'(rsp[0].data_ok), 64'd0);
    chk("b2b_end_busy", 64'(busy[0]), 64'd0);

    // Asynchronous reset in the middle of a write's WAIT (LATENCY=2).
    bd_write(1, 10'd9, 64'h99998888_77776666);
    req[1].valid  = 1'b1;
    req[1].addr   = 64'h48;
    req[1].strobe = 8'hFF;
    req[1].data   = 64'h0;
    @(posedge clk); #1;
    chk("rst_mid_busy", 64'(busy[1]), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_data_ok", 64'(rsp[1].data_ok), 64'd0);
    chk("rst_async_addr_ok", 64'(rsp[1].addr_ok), 64'd0);
    chk("rst_async_data", rsp[1].data, 64'd0);
    chk("rst_async_busy", 64'(busy[1]), 64'd0);
    req[1].valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    txn(1, 64'h48, 8'h00, 64'h0, 64'h99998888_77776666, "rst_word_kept");

    // Bus write and backdoor write to the same word on the same edge.
    req[0].valid  = 1'b1;
    req[0].addr   = 64'h18;
    req[0].strobe = 8'h01;
    req[0].data   = 64'h00000000_000000AB;
    @(posedge clk); #1;
    chk("collide_resp", 64'(rsp[0].data_ok), 64'd1);
    req[0].valid = 1'b0;
    bd_we[0]     = 1'b1;
    bd_addr[0]   = 10'd3;
    bd_data[0]   = 64'h55555555_55555555;
    @(posedge clk); #1;
    bd_we[0] = 1'b0;
    txn(0, 64'h18, 8'h00, 64'h0, 64'h55555555_555555AB, "collide_read");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
